// File: rtl/nested_interrupt_controller.sv
// Nested interrupt controller: latches edge/software requests, arbitrates by
// priority and tracks in-service handlers on a bounded stack for preemption.
module nested_interrupt_controller #(
    parameter int NUM_SRC    = 32,
    parameter int ID_W       = $clog2(NUM_SRC),
    parameter int PRIO_W     = 3,
    parameter int NEST_DEPTH = 4,
    parameter int DEPTH_W    = $clog2(NEST_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        flag_signals,
    input  logic [NUM_SRC-1:0]        flag_signals_sw,
    input  logic [NUM_SRC-1:0]        int_enable,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_cfg,
    input  logic                      gie,
    input  logic                      ack_start,
    input  logic [ID_W-1:0]           ack_start_id,
    input  logic                      ack_end,
    input  logic [ID_W-1:0]           ack_end_id,
    output logic                      int_flag,
    output logic [ID_W-1:0]           int_ID,
    output logic [PRIO_W-1:0]         _priority,
    output logic [NUM_SRC-1:0]        pending,
    output logic [DEPTH_W-1:0]        active_depth,
    output logic                      ack_err
);

    localparam logic [DEPTH_W-1:0] MAX_DEPTH = DEPTH_W'(NEST_DEPTH);

    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] set_hw;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] cand;

    logic [ID_W-1:0]    stk_id_q   [NEST_DEPTH];
    logic [ID_W-1:0]    stk_id_d   [NEST_DEPTH];
    logic [PRIO_W-1:0]  stk_prio_q [NEST_DEPTH];
    logic [PRIO_W-1:0]  stk_prio_d [NEST_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;
    logic [DEPTH_W-1:0] depth_mid;

    logic               int_flag_q;
    logic               int_flag_d;
    logic [ID_W-1:0]    int_id_q;
    logic [ID_W-1:0]    int_id_d;
    logic [PRIO_W-1:0]  int_prio_q;
    logic [PRIO_W-1:0]  int_prio_d;
    logic               ack_err_q;
    logic               ack_err_d;

    logic [ID_W-1:0]    top_id;
    logic [PRIO_W-1:0]  top_prio;
    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [PRIO_W-1:0]  win_prio;
    logic               start_pend;
    logic [PRIO_W-1:0]  start_prio;
    logic               end_ok;
    logic               start_ok;
    logic               beats_run;

    assign set_hw = flag_signals & ~prev_q;
    assign cand   = pending_q & int_enable;

    always_comb begin
        top_id   = '0;
        top_prio = '0;
        for (int k = 0; k < NEST_DEPTH; k++) begin
            if (DEPTH_W'(k + 1) == depth_q) begin
                top_id   = stk_id_q[k];
                top_prio = stk_prio_q[k];
            end
        end
    end

    // Upward scan with strict compare keeps the lowest index on ties.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_prio  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand[i] &&
                (!win_found || prio_cfg[i*PRIO_W +: PRIO_W] > win_prio)) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
                win_prio  = prio_cfg[i*PRIO_W +: PRIO_W];
            end
        end
    end

    always_comb begin
        start_pend = 1'b0;
        start_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ID_W'(i) == ack_start_id) begin
                start_pend = pending_q[i];
                start_prio = prio_cfg[i*PRIO_W +: PRIO_W];
            end
        end
    end

    // The retire is resolved first so a same-cycle start sees the popped depth.
    assign end_ok    = ack_end && (depth_q != '0) && (top_id == ack_end_id);
    assign depth_mid = end_ok ? depth_q - DEPTH_W'(1) : depth_q;
    assign start_ok  = ack_start && start_pend && (depth_mid < MAX_DEPTH);
    assign ack_err_d = (ack_end && !end_ok) || (ack_start && !start_ok);

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr[i] = start_ok && (ID_W'(i) == ack_start_id);
        end
    end

    assign pending_d = (pending_q & ~clr) | set_hw | flag_signals_sw;

    always_comb begin
        stk_id_d   = stk_id_q;
        stk_prio_d = stk_prio_q;
        for (int k = 0; k < NEST_DEPTH; k++) begin
            if (start_ok && (DEPTH_W'(k) == depth_mid)) begin
                stk_id_d[k]   = ack_start_id;
                stk_prio_d[k] = start_prio;
            end
        end
    end

    assign depth_d = start_ok ? depth_mid + DEPTH_W'(1) : depth_mid;

    assign beats_run  = (depth_q == '0) || (win_prio > top_prio);
    assign int_flag_d = gie && win_found && beats_run && (depth_q < MAX_DEPTH);
    assign int_id_d   = int_flag_d ? win_id : int_id_q;
    assign int_prio_d = int_flag_d ? win_prio : int_prio_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            pending_q  <= '0;
            depth_q    <= '0;
            int_flag_q <= 1'b0;
            int_id_q   <= '0;
            int_prio_q <= '0;
            ack_err_q  <= 1'b0;
            for (int k = 0; k < NEST_DEPTH; k++) begin
                stk_id_q[k]   <= '0;
                stk_prio_q[k] <= '0;
            end
        end else begin
            prev_q     <= flag_signals;
            pending_q  <= pending_d;
            depth_q    <= depth_d;
            int_flag_q <= int_flag_d;
            int_id_q   <= int_id_d;
            int_prio_q <= int_prio_d;
            ack_err_q  <= ack_err_d;
            stk_id_q   <= stk_id_d;
            stk_prio_q <= stk_prio_d;
        end
    end

    assign int_flag     = int_flag_q;
    assign int_ID       = int_id_q;
    assign _priority    = int_prio_q;
    assign pending      = pending_q;
    assign active_depth = depth_q;
    assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_nested_interrupt_controller.sv
// Bench for nested_interrupt_controller: directed scenarios with literal
// expectations, then random traffic against a queue-based reference model.
module tb_nested_interrupt_controller;

    localparam int NS = 32;
    localparam int IW = 5;
    localparam int PW = 3;
    localparam int ND = 4;
    localparam int DW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NS-1:0]   flag_signals;
    logic [NS-1:0]   flag_signals_sw;
    logic [NS-1:0]   int_enable;
    logic [NS*PW-1:0] prio_cfg;
    logic            gie;
    logic            ack_start;
    logic [IW-1:0]   ack_start_id;
    logic            ack_end;
    logic [IW-1:0]   ack_end_id;
    logic            int_flag;
    logic [IW-1:0]   int_ID;
    logic [PW-1:0]   _priority;
    logic [NS-1:0]   pending;
    logic [DW-1:0]   active_depth;
    logic            ack_err;

    always #5 clk = ~clk;

    nested_interrupt_controller #(
        .NUM_SRC(NS), .ID_W(IW), .PRIO_W(PW), .NEST_DEPTH(ND), .DEPTH_W(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .flag_signals(flag_signals), .flag_signals_sw(flag_signals_sw),
        .int_enable(int_enable), .prio_cfg(prio_cfg), .gie(gie),
        .ack_start(ack_start), .ack_start_id(ack_start_id),
        .ack_end(ack_end), .ack_end_id(ack_end_id),
        .int_flag(int_flag), .int_ID(int_ID), ._priority(_priority),
        .pending(pending), .active_depth(active_depth), .ack_err(ack_err)
    );

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    // Reference model state (m_*) and its next value (x_*)
    logic [NS-1:0] m_pend, m_prev, x_pend, x_prev;
    int  m_sid[$], m_spr[$], x_sid[$], x_spr[$];
    bit  m_flag, m_err, x_flag, x_err;
    int  m_id, m_pr, x_id, x_pr;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_step();
        int bi, bp, run, s;
        bit eok, sok;
        x_sid = m_sid;
        x_spr = m_spr;
        if (rst) begin
            x_pend = '0; x_prev = '0;
            x_sid.delete(); x_spr.delete();
            x_flag = 1'b0; x_id = 0; x_pr = 0; x_err = 1'b0;
            return;
        end
        bi = -1;
        bp = -1;
        for (int i = 0; i < NS; i++) begin
            if (m_pend[i] && int_enable[i] && int'(prio_cfg[i*PW +: PW]) > bp) begin
                bi = i;
                bp = int'(prio_cfg[i*PW +: PW]);
            end
        end
        run = (m_sid.size() == 0) ? -1 : m_spr[$];
        x_flag = gie && (bi >= 0) && (bp > run) && (m_sid.size() < ND);
        x_id = x_flag ? bi : m_id;
        x_pr = x_flag ? bp : m_pr;
        eok = ack_end && (m_sid.size() > 0) && (m_sid[$] == int'(ack_end_id));
        if (eok) begin
            void'(x_sid.pop_back());
            void'(x_spr.pop_back());
        end
        s = int'(ack_start_id);
        sok = ack_start && m_pend[s] && (x_sid.size() < ND);
        x_pend = m_pend;
        if (sok) begin
            x_sid.push_back(s);
            x_spr.push_back(int'(prio_cfg[s*PW +: PW]));
            x_pend[s] = 1'b0;
        end
        x_pend = x_pend | (flag_signals & ~m_prev) | flag_signals_sw;
        x_prev = flag_signals;
        x_err = (ack_end && !eok) || (ack_start && !sok);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        m_pend = x_pend; m_prev = x_prev;
        m_sid = x_sid; m_spr = x_spr;
        m_flag = x_flag; m_id = x_id; m_pr = x_pr; m_err = x_err;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("int_flag", 64'(int_flag), 64'(m_flag));
            chk("int_ID", 64'(int_ID), 64'(m_id));
            chk("priority", 64'(_priority), 64'(m_pr));
            chk("pending", 64'(pending), 64'(m_pend));
            chk("active_depth", 64'(active_depth), 64'(m_sid.size()));
            chk("ack_err", 64'(ack_err), 64'(m_err));
        end
    end

    task automatic setp(int i, int p);
        prio_cfg[i*PW +: PW] = PW'(p);
    endtask

    task automatic sw_pulse(int i);
        flag_signals_sw[i] = 1'b1;
        cycle();
        flag_signals_sw = '0;
    endtask

    task automatic astart(int id);
        ack_start = 1'b1;
        ack_start_id = IW'(id);
        cycle();
        ack_start = 1'b0;
    endtask

    task automatic aend(int id);
        ack_end = 1'b1;
        ack_end_id = IW'(id);
        cycle();
        ack_end = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flag_signals = '0; flag_signals_sw = '0;
        int_enable = '1; prio_cfg = '0; gie = 1'b1;
        ack_start = 1'b0; ack_start_id = '0;
        ack_end = 1'b0; ack_end_id = '0;
        cycle();
        cycle();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst int_flag", 64'(int_flag), 64'(0));
        chk("rst int_ID", 64'(int_ID), 64'(0));
        chk("rst pending", 64'(pending), 64'(0));
        chk("rst depth", 64'(active_depth), 64'(0));
        chk("rst ack_err", 64'(ack_err), 64'(0));

        // Single hardware request
        setp(2, 3);
        flag_signals[2] = 1'b1;
        cycle();
        chk("single pend", 64'(pending[2]), 64'(1));
        chk("single flag early", 64'(int_flag), 64'(0));
        cycle();
        chk("single flag", 64'(int_flag), 64'(1));
        chk("single id", 64'(int_ID), 64'(2));
        chk("single prio", 64'(_priority), 64'(3));
        astart(2);
        chk("single clr", 64'(pending[2]), 64'(0));
        chk("single depth", 64'(active_depth), 64'(1));
        cycle();
        chk("single drop", 64'(int_flag), 64'(0));
        flag_signals = '0;

        // Tie goes to lowest index, then higher priority wins
        do_reset();
        setp(2, 4); setp(5, 4);
        flag_signals_sw = (NS'(1) << 2) | (NS'(1) << 5);
        cycle();
        flag_signals_sw = '0;
        cycle();
        chk("tie id", 64'(int_ID), 64'(2));
        do_reset();
        setp(5, 6);
        flag_signals_sw = (NS'(1) << 2) | (NS'(1) << 5);
        cycle();
        flag_signals_sw = '0;
        cycle();
        chk("arb id", 64'(int_ID), 64'(5));
        chk("arb prio", 64'(_priority), 64'(6));

        // Nesting and preemption
        do_reset();
        setp(2, 3); setp(7, 5); setp(9, 4);
        sw_pulse(2);
        cycle();
        astart(2);
        sw_pulse(7);
        cycle();
        chk("nest id", 64'(int_ID), 64'(7));
        chk("nest prio", 64'(_priority), 64'(5));
        astart(7);
        chk("nest depth", 64'(active_depth), 64'(2));
        sw_pulse(9);
        cycle();
        cycle();
        chk("no preempt", 64'(int_flag), 64'(0));

        // Illegal acks
        aend(2);
        chk("bad end err", 64'(ack_err), 64'(1));
        chk("bad end depth", 64'(active_depth), 64'(2));
        cycle();
        chk("err pulse", 64'(ack_err), 64'(0));
        astart(11);
        chk("bad start err", 64'(ack_err), 64'(1));
        chk("bad start pend", 64'(pending), 64'(32'h200));
        aend(7);
        chk("pop depth", 64'(active_depth), 64'(1));
        cycle();
        chk("after pop flag", 64'(int_flag), 64'(1));
        chk("after pop id", 64'(int_ID), 64'(9));

        // Depth limit
        astart(9);
        setp(12, 6); setp(13, 7); setp(14, 7);
        flag_signals_sw = (NS'(7) << 12);
        cycle();
        flag_signals_sw = '0;
        astart(12);
        astart(13);
        chk("full depth", 64'(active_depth), 64'(4));
        astart(14);
        chk("full err", 64'(ack_err), 64'(1));
        chk("full hold", 64'(active_depth), 64'(4));
        cycle();
        cycle();
        chk("full no flag", 64'(int_flag), 64'(0));

        // Set/clear collision, then reset mid-nest
        do_reset();
        setp(3, 2);
        sw_pulse(3);
        flag_signals_sw[3] = 1'b1;
        astart(3);
        flag_signals_sw = '0;
        chk("collide pend", 64'(pending[3]), 64'(1));
        chk("collide depth", 64'(active_depth), 64'(1));
        rst = 1'b1;
        astart(3);
        rst = 1'b0;
        chk("mid rst depth", 64'(active_depth), 64'(0));
        chk("mid rst pend", 64'(pending), 64'(0));
        chk("mid rst flag", 64'(int_flag), 64'(0));

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            flag_signals = flag_signals ^ ($urandom & $urandom & $urandom);
            flag_signals_sw = ($urandom_range(0, 3) == 0) ?
                (NS'(1) << $urandom_range(0, NS - 1)) : '0;
            if ($urandom_range(0, 15) == 0) int_enable = $urandom | $urandom;
            if ($urandom_range(0, 7) == 0)
                setp(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 7)));
            gie = ($urandom_range(0, 9) != 0);
            ack_start = ($urandom_range(0, 3) == 0);
            ack_start_id = (m_flag && $urandom_range(0, 3) != 0) ?
                IW'(m_id) : IW'($urandom_range(0, NS - 1));
            ack_end = ($urandom_range(0, 4) == 0);
            ack_end_id = (m_sid.size() > 0 && $urandom_range(0, 4) != 0) ?
                IW'(m_sid[$]) : IW'($urandom_range(0, NS - 1));
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0;
        ack_start = 1'b0;
        ack_end = 1'b0;
        cycle();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/nested_interrupt_controller.md
Name: nested_interrupt_controller

Overview:
- Parametrised successor of the single-level interrupt controller.
- Latches hardware edge and software-set requests from NUM_SRC sources, each with a programmable priority.
- Arbitrates among pending, enabled sources and raises int_flag/int_ID/_priority toward the interrupt decider.
- Tracks nested in-service interrupts on a NEST_DEPTH stack, so only strictly higher-priority requests preempt the running handler.

Parameters:
NUM_SRC, 32, number of interrupt sources
ID_W, $clog2(NUM_SRC), width of source IDs
PRIO_W, 3, width of per-source priority (larger value = more urgent)
NEST_DEPTH, 4, maximum in-service nesting depth

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
flag_signals  in  NUM_SRC  hardware request lines, rising-edge detected
flag_signals_sw  in  NUM_SRC  software set, one-cycle pulse per bit
int_enable  in  NUM_SRC  per-source enable mask
prio_cfg  in  NUM_SRC*PRIO_W  priority of source i in bits [i*PRIO_W +: PRIO_W]
gie  in  1  global interrupt enable
ack_start  in  1  processor entered handler ack_start_id
ack_start_id  in  ID_W  ID being serviced
ack_end  in  1  processor finished handler ack_end_id
ack_end_id  in  ID_W  ID being retired
int_flag  out  1  request to processor
int_ID  out  ID_W  selected source
_priority  out  PRIO_W  priority of selected source
pending  out  NUM_SRC  pending register
active_depth  out  $clog2(NEST_DEPTH+1)  current stack depth
ack_err  out  1  one-cycle pulse on an illegal ack

Behaviour:
- Reset state:
  - Pending cleared, edge-detect history cleared, stack emptied.
  - int_flag=0, int_ID=0, _priority=0, active_depth=0, ack_err=0.
- Edge detect:
  - Registered prev of flag_signals.
  - set_hw[i] = flag_signals[i] & ~prev[i].
- Pending update, per cycle:
  - pending[i] <= (pending[i] & ~clr[i]) | set_hw[i] | flag_signals_sw[i].
  - clr[i] = accepted ack_start for ID i.
  - Set wins over clear in the same cycle.
- Arbitration (combinational):
  - Candidates = pending & int_enable.
  - Winner = highest prio_cfg value.
  - Tie goes to the lowest index.
- Running priority:
  - Priority of the stack top entry.
  - "None" when the stack is empty; any candidate beats "none".
- Request output (registered):
  - int_flag <= gie & candidate_exists & (winner_prio > running_prio) & (depth < NEST_DEPTH).
  - int_ID/_priority track the winner when int_flag is set; otherwise they hold their last value.
- Latency:
  - Edge at cycle N -> pending at N+1 -> int_flag at N+2.
  - SW pulse has the same latency.
- ack_start:
  - Accepted only if pending[ack_start_id]=1 and depth < NEST_DEPTH.
  - On accept: push {id, prio_cfg[id]} (priority captured at push), clear pending, depth+1.
  - Otherwise: ack_err pulse, no state change.
- ack_end:
  - Accepted only if depth > 0 and stack top ID == ack_end_id.
  - On accept: pop, depth-1.
  - Otherwise: ack_err pulse, no pop (out-of-order retire is illegal).
- Simultaneous ack_end and ack_start:
  - ack_end is evaluated first against the current top, then ack_start against the post-pop depth.
  - Both may succeed in one cycle (net depth unchanged).
- gie low: int_flag deasserts next cycle; pending still accumulates.
- Disabled source: stays pending, is never selected, and is selected once re-enabled.
- Stack full: no new int_flag until a pop.
- Reset asserted mid-operation: all state returns to reset values at the next clk edge, regardless of acks in flight.

Test Plan:
- Single request:
  - Stimulus: prio_cfg[2]=3, pulse flag_signals[2] at cycle 1, gie=1.
  - Response: pending[2]=1 at cycle 2; int_flag=1, int_ID=2, _priority=3 at cycle 3.
  - Then: ack_start id 2 clears pending[2], active_depth=1, and int_flag drops.
- Arbitration:
  - Stimulus: sources 2 and 5 both at priority 4, asserted together.
  - Response: int_ID=2.
  - Then: set prio_cfg[5]=6 and repeat -> int_ID=5.
- Nesting and preemption:
  - Stimulus: service ID 2 (priority 3); raise ID 7 (priority 5) -> int_flag with int_ID=7; ack_start 7 -> depth 2.
  - Response: a priority-4 request raised now does not assert int_flag until ack_end 7 pops the stack.
- Illegal acks:
  - Stimulus A: ack_end id 2 while the top is 7.
  - Stimulus B: ack_start for a non-pending ID.
  - Response: ack_err pulses one cycle each; depth and pending unchanged.
- Depth limit:
  - Stimulus: NEST_DEPTH=4, four nested acks accepted, then a fifth ack_start.
  - Response: ack_err=1, depth stays 4, int_flag stays 0.
- Set/clear collision and reset:
  - Stimulus: flag_signals_sw[3] pulses in the same cycle as ack_start id 3.
  - Response: pending[3] stays 1.
  - Then: rst for one cycle mid-nest -> depth=0, pending=0, int_flag=0.
